// File: rtl/m_trap_ctrl_pkg.sv
// Shared types for the machine-mode trap controller: cause codes, CSR map,
// MSTATUS/MIE/MIP bit positions and the trap FSM encoding.
package m_trap_ctrl_pkg;

  localparam int XLEN    = 32;
  localparam int ECODE_W = 5;

  typedef enum logic [ECODE_W-1:0] {
    INST_MISALIGNED    = 5'd0,
    INST_ACCESS_FAULT  = 5'd1,
    ILLEGAL_INST       = 5'd2,
    BREAKPOINT         = 5'd3,
    LOAD_MISALIGNED    = 5'd4,
    LOAD_ACCESS_FAULT  = 5'd5,
    STORE_MISALIGNED   = 5'd6,
    STORE_ACCESS_FAULT = 5'd7,
    ECALL_U            = 5'd8,
    ECALL_S            = 5'd9,
    ECALL_M            = 5'd11
  } exception_code_t;

  typedef enum logic [ECODE_W-1:0] {
    IRQ_M_SOFT  = 5'd3,
    IRQ_M_TIMER = 5'd7,
    IRQ_M_EXT   = 5'd11
  } interrupt_code_t;

  typedef enum logic [11:0] {
    CSR_MSTATUS = 12'h300,
    CSR_MIE     = 12'h304,
    CSR_MTVEC   = 12'h305,
    CSR_MEPC    = 12'h341,
    CSR_MCAUSE  = 12'h342,
    CSR_MTVAL   = 12'h343,
    CSR_MIP     = 12'h344
  } csr_t;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int MIX_MSI = 3;
  localparam int MIX_MTI = 7;
  localparam int MIX_MEI = 11;
  localparam logic [XLEN-1:0] MIX_MASK = 32'h0000_0888;

  typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} trap_state_t;
  typedef enum logic [1:0] {DIRECT = 2'b00, VECTORED = 2'b01} mtvec_mode_t;

  // Reserved modes (2, 3) and disabled vectoring both collapse to DIRECT.
  function automatic logic [XLEN-1:0] legal_mtvec(input logic [XLEN-1:0] wdata,
                                                  input logic            vec_en);
    if (wdata[1:0] == VECTORED && vec_en)
      return wdata;
    return {wdata[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/m_trap_ctrl_if.sv
// Commit-stage / fetch / CSR-unit signals seen by the trap controller.
interface m_trap_ctrl_if;
  import m_trap_ctrl_pkg::*;

  logic            exc_valid;
  exception_code_t exc_code;
  logic [XLEN-1:0] exc_pc;
  logic [XLEN-1:0] exc_tval;
  logic [XLEN-1:0] next_pc;
  logic            mret_valid;
  logic            meip;
  logic            mtip;
  logic            msip;
  logic            pipeline_empty;
  logic            flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;
  logic            busy;
  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_hit;

  modport master (
    output exc_valid, exc_code, exc_pc, exc_tval, next_pc, mret_valid,
           meip, mtip, msip, pipeline_empty, redirect_ready,
           csr_we, csr_addr, csr_wdata,
    input  flush, redirect_valid, redirect_pc, busy, csr_rdata, csr_hit
  );

  modport slave (
    input  exc_valid, exc_code, exc_pc, exc_tval, next_pc, mret_valid,
           meip, mtip, msip, pipeline_empty, redirect_ready,
           csr_we, csr_addr, csr_wdata,
    output flush, redirect_valid, redirect_pc, busy, csr_rdata, csr_hit
  );

endinterface

// File: rtl/m_trap_ctrl_irq_prio.sv
// Fixed-priority machine interrupt encoder: MEI > MSI > MTI.
module m_irq_prio
  import m_trap_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] pend_i,
  output logic            pending_o,
  output interrupt_code_t code_o
);

  always_comb begin
    pending_o = |pend_i;
    code_o    = IRQ_M_TIMER;
    if (pend_i[MIX_MEI])
      code_o = IRQ_M_EXT;
    else if (pend_i[MIX_MSI])
      code_o = IRQ_M_SOFT;
  end

endmodule

// File: rtl/m_trap_ctrl.sv
// Machine-mode trap controller: exception/interrupt/MRET arbitration, trap
// CSRs, and the flush -> drain -> redirect handshake with the pipeline.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | accepting exceptions, interrupts and MRET
//   DRAIN    | flush issued, waiting for pipeline_empty; trap CSRs commit
//   REDIRECT | redirect_valid held with a stable target until accepted
module m_trap_ctrl
  import m_trap_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit              VECTORED_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  m_trap_ctrl_if.slave  bus
);

  trap_state_t     state_q;
  logic            flush_q, redirect_valid_q, busy_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic            mstatus_mie_q, mstatus_mpie_q;
  logic [XLEN-1:0] mie_q, mtvec_q, mepc_q, mcause_q, mtval_q;

  logic [XLEN-1:0] cause_q, epc_q, tval_q;
  logic            mret_q;

  logic [XLEN-1:0] mip_d, mstatus_rd_d, irq_pend_d, trap_base_d, target_d;
  logic [XLEN-1:0] csr_rdata_d;
  logic            csr_hit_d;
  logic            irq_valid_d;
  interrupt_code_t irq_code_d;

  always_comb begin
    mip_d          = '0;
    mip_d[MIX_MEI] = bus.meip;
    mip_d[MIX_MTI] = bus.mtip;
    mip_d[MIX_MSI] = bus.msip;
  end

  always_comb begin
    mstatus_rd_d                                = '0;
    mstatus_rd_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_rd_d[MSTATUS_MPIE]                  = mstatus_mpie_q;
    mstatus_rd_d[MSTATUS_MIE]                   = mstatus_mie_q;
  end

  assign irq_pend_d = mip_d & mie_q & {XLEN{mstatus_mie_q}};

  m_irq_prio u_irq_prio (
    .pend_i    (irq_pend_d),
    .pending_o (irq_valid_d),
    .code_o    (irq_code_d)
  );

  assign trap_base_d = {mtvec_q[XLEN-1:2], 2'b00};

  always_comb begin
    target_d = trap_base_d;
    if (mret_q)
      target_d = epc_q;
    else if (cause_q[XLEN-1] && mtvec_q[1:0] == VECTORED)
      target_d = trap_base_d + {25'b0, cause_q[ECODE_W-1:0], 2'b00};
  end

  always_comb begin
    csr_hit_d   = 1'b1;
    csr_rdata_d = '0;
    case (bus.csr_addr)
      CSR_MSTATUS: csr_rdata_d = mstatus_rd_d;
      CSR_MIE:     csr_rdata_d = mie_q;
      CSR_MTVEC:   csr_rdata_d = mtvec_q;
      CSR_MEPC:    csr_rdata_d = mepc_q;
      CSR_MCAUSE:  csr_rdata_d = mcause_q;
      CSR_MTVAL:   csr_rdata_d = mtval_q;
      CSR_MIP:     csr_rdata_d = mip_d;
      default:     csr_hit_d   = 1'b0;
    endcase
  end

  assign bus.csr_rdata      = csr_rdata_d;
  assign bus.csr_hit        = csr_hit_d;
  assign bus.flush          = flush_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.busy           = busy_q;

  // CSR writes come first so that trap/MRET updates below take precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      busy_q           <= 1'b0;
      mstatus_mie_q    <= 1'b0;
      mstatus_mpie_q   <= 1'b0;
      mie_q            <= '0;
      mtvec_q          <= MTVEC_RESET;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      cause_q          <= '0;
      epc_q            <= '0;
      tval_q           <= '0;
      mret_q           <= 1'b0;
    end else begin
      if (bus.csr_we) begin
        case (bus.csr_addr)
          CSR_MSTATUS: begin
            mstatus_mie_q  <= bus.csr_wdata[MSTATUS_MIE];
            mstatus_mpie_q <= bus.csr_wdata[MSTATUS_MPIE];
          end
          CSR_MIE:    mie_q    <= bus.csr_wdata & MIX_MASK;
          CSR_MTVEC:  mtvec_q  <= legal_mtvec(bus.csr_wdata, VECTORED_EN);
          CSR_MEPC:   mepc_q   <= {bus.csr_wdata[XLEN-1:2], 2'b00};
          CSR_MCAUSE: mcause_q <= bus.csr_wdata;
          CSR_MTVAL:  mtval_q  <= bus.csr_wdata;
          default: ;
        endcase
      end

      case (state_q)
        IDLE: begin
          if (bus.exc_valid) begin
            cause_q <= {1'b0, 26'b0, bus.exc_code};
            epc_q   <= bus.exc_pc;
            tval_q  <= bus.exc_tval;
            mret_q  <= 1'b0;
            flush_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= DRAIN;
          end else if (irq_valid_d) begin
            cause_q <= {1'b1, 26'b0, irq_code_d};
            epc_q   <= bus.next_pc;
            tval_q  <= '0;
            mret_q  <= 1'b0;
            flush_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= DRAIN;
          end else if (bus.mret_valid) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
            epc_q          <= mepc_q;
            mret_q         <= 1'b1;
            flush_q        <= 1'b1;
            busy_q         <= 1'b1;
            state_q        <= DRAIN;
          end
        end

        DRAIN: begin
          flush_q <= 1'b0;
          // pipeline_empty is not trusted in the flush cycle itself; the kill
          // has not reached the pipeline yet.
          if (bus.pipeline_empty && !flush_q) begin
            if (!mret_q) begin
              mepc_q         <= {epc_q[XLEN-1:2], 2'b00};
              mcause_q       <= cause_q;
              mtval_q        <= tval_q;
              mstatus_mpie_q <= mstatus_mie_q;
              mstatus_mie_q  <= 1'b0;
            end
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= target_d;
            state_q          <= REDIRECT;
          end
        end

        REDIRECT: begin
          if (bus.redirect_ready) begin
            redirect_valid_q <= 1'b0;
            busy_q           <= 1'b0;
            state_q          <= IDLE;
          end
        end

        default: begin
          flush_q          <= 1'b0;
          redirect_valid_q <= 1'b0;
          busy_q           <= 1'b0;
          state_q          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_trap_ctrl.sv
// Directed bench for m_trap_ctrl: CSR table vectors plus hand-built trap,
// interrupt, MRET and reset sequences.
module tb_m_trap_ctrl;
  import m_trap_ctrl_pkg::*;

  localparam logic [31:0] RST_MTVEC = 32'h0000_0100;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  m_trap_ctrl_if bus ();

  m_trap_ctrl #(
    .MTVEC_RESET (RST_MTVEC),
    .VECTORED_EN (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_hit;
  } csr_vec_t;

  typedef struct {
    logic        meip;
    logic        mtip;
    logic        msip;
    logic [31:0] exp;
  } mip_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    bus.csr_we    = 1'b1;
    bus.csr_addr  = a;
    bus.csr_wdata = d;
    step();
    bus.csr_we    = 1'b0;
  endtask

  task automatic chk_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
    bus.csr_addr = a;
    @(negedge clk);
    check(name, bus.csr_rdata, exp);
  endtask

  task automatic wait_flush(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (bus.flush) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_rv(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (bus.redirect_valid) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    csr_vec_t vecs [12];
    mip_vec_t mips [4];
    int       n;
    int       cnt;

    vecs[0]  = '{CSR_MSTATUS, 32'hFFFF_FFFF, 32'h0000_1888, 1'b1};
    vecs[1]  = '{CSR_MSTATUS, 32'h0000_0000, 32'h0000_1800, 1'b1};
    vecs[2]  = '{CSR_MIE,     32'hFFFF_FFFF, 32'h0000_0888, 1'b1};
    vecs[3]  = '{CSR_MIE,     32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[4]  = '{CSR_MIP,     32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[5]  = '{CSR_MEPC,    32'h1234_5677, 32'h1234_5674, 1'b1};
    vecs[6]  = '{CSR_MTVEC,   32'h0000_0103, 32'h0000_0100, 1'b1};
    vecs[7]  = '{CSR_MTVEC,   32'h0000_1202, 32'h0000_1200, 1'b1};
    vecs[8]  = '{CSR_MTVEC,   32'h0000_0101, 32'h0000_0101, 1'b1};
    vecs[9]  = '{CSR_MCAUSE,  32'h8000_0007, 32'h8000_0007, 1'b1};
    vecs[10] = '{CSR_MTVAL,   32'hCAFE_BABE, 32'hCAFE_BABE, 1'b1};
    vecs[11] = '{12'h340,     32'h0000_1234, 32'h0000_0000, 1'b0};

    mips[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0800};
    mips[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0080};
    mips[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0008};
    mips[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0888};

    n_checks = 0;
    n_fail   = 0;

    rst_n              = 1'b0;
    bus.exc_valid      = 1'b0;
    bus.exc_code       = INST_MISALIGNED;
    bus.exc_pc         = '0;
    bus.exc_tval       = '0;
    bus.next_pc        = '0;
    bus.mret_valid     = 1'b0;
    bus.meip           = 1'b0;
    bus.mtip           = 1'b0;
    bus.msip           = 1'b0;
    bus.pipeline_empty = 1'b1;
    bus.redirect_ready = 1'b1;
    bus.csr_we         = 1'b0;
    bus.csr_addr       = '0;
    bus.csr_wdata      = '0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Reset state
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_flush", bus.flush, 1'b0);
    check1("rst_rv", bus.redirect_valid, 1'b0);
    check("rst_rpc", bus.redirect_pc, 32'h0);
    chk_csr("rst_mtvec", CSR_MTVEC, RST_MTVEC);
    chk_csr("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
    chk_csr("rst_mcause", CSR_MCAUSE, 32'h0);
    chk_csr("rst_mepc", CSR_MEPC, 32'h0);
    chk_csr("rst_mie", CSR_MIE, 32'h0);

    // CSR write/read vectors
    for (int i = 0; i < 12; i++) begin
      csr_wr(vecs[i].addr, vecs[i].wdata);
      bus.csr_addr = vecs[i].addr;
      @(negedge clk);
      check($sformatf("csr_vec%0d_rd", i), bus.csr_rdata, vecs[i].exp_rd);
      check1($sformatf("csr_vec%0d_hit", i), bus.csr_hit, vecs[i].exp_hit);
    end

    // MIP reflects interrupt lines (MIE=0 so nothing is taken)
    for (int i = 0; i < 4; i++) begin
      bus.meip = mips[i].meip;
      bus.mtip = mips[i].mtip;
      bus.msip = mips[i].msip;
      chk_csr($sformatf("mip_vec%0d", i), CSR_MIP, mips[i].exp);
    end
    bus.meip = 1'b0;
    bus.mtip = 1'b0;
    bus.msip = 1'b0;
    step();

    // Illegal-instruction exception with a slow drain
    csr_wr(CSR_MTVEC, 32'h0000_0200);
    bus.pipeline_empty = 1'b0;
    bus.exc_valid      = 1'b1;
    bus.exc_code       = ILLEGAL_INST;
    bus.exc_pc         = 32'h0000_0100;
    bus.exc_tval       = 32'h0000_DEAD;
    step();
    bus.exc_valid = 1'b0;
    check1("exc_flush", bus.flush, 1'b1);
    check1("exc_busy", bus.busy, 1'b1);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.flush || bus.redirect_valid || !bus.busy) cnt++;
    end
    check("exc_drain_hold", cnt, 0);
    bus.pipeline_empty = 1'b1;
    wait_rv(10, n);
    check("exc_rv_latency", n, 1);
    check("exc_rpc", bus.redirect_pc, 32'h0000_0200);
    step();
    check1("exc_done_busy", bus.busy, 1'b0);
    check1("exc_done_rv", bus.redirect_valid, 1'b0);
    chk_csr("exc_mepc", CSR_MEPC, 32'h0000_0100);
    chk_csr("exc_mcause", CSR_MCAUSE, 32'h0000_0002);
    chk_csr("exc_mtval", CSR_MTVAL, 32'h0000_DEAD);
    chk_csr("exc_mstatus", CSR_MSTATUS, 32'h0000_1800);

    // Vectored interrupt, MEI beats MTI, minimum latency
    bus.meip    = 1'b1;
    bus.mtip    = 1'b1;
    bus.next_pc = 32'h0000_0044;
    csr_wr(CSR_MTVEC, 32'h0000_0201);
    csr_wr(CSR_MIE, 32'h0000_0880);
    csr_wr(CSR_MSTATUS, 32'h0000_0008);
    wait_flush(5, n);
    check("irq_take_latency", n, 1);
    wait_rv(10, n);
    check("irq_rv_latency", n, 2);
    check("irq_rpc", bus.redirect_pc, 32'h0000_022C);
    step();
    bus.meip = 1'b0;
    bus.mtip = 1'b0;
    chk_csr("irq_mcause", CSR_MCAUSE, 32'h8000_000B);
    chk_csr("irq_mepc", CSR_MEPC, 32'h0000_0044);
    chk_csr("irq_mtval", CSR_MTVAL, 32'h0);
    chk_csr("irq_mstatus", CSR_MSTATUS, 32'h0000_1880);

    // Exception beats same-cycle MSI; MSI taken after MRET
    csr_wr(CSR_MIE, 32'h0000_0008);
    bus.msip = 1'b1;
    csr_wr(CSR_MSTATUS, 32'h0000_0008);
    bus.exc_valid = 1'b1;
    bus.exc_code  = ECALL_M;
    bus.exc_pc    = 32'h0000_0500;
    bus.exc_tval  = 32'h0;
    step();
    bus.exc_valid = 1'b0;
    check1("ecall_flush", bus.flush, 1'b1);
    wait_rv(10, n);
    check("ecall_rv_latency", n, 2);
    check("ecall_rpc", bus.redirect_pc, 32'h0000_0200);
    step();
    chk_csr("ecall_mcause", CSR_MCAUSE, 32'h0000_000B);
    chk_csr("ecall_mepc", CSR_MEPC, 32'h0000_0500);
    chk_csr("ecall_mstatus", CSR_MSTATUS, 32'h0000_1880);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.flush || bus.busy) cnt++;
    end
    check("ecall_msi_masked", cnt, 0);
    bus.mret_valid = 1'b1;
    step();
    bus.mret_valid = 1'b0;
    check1("mret1_flush", bus.flush, 1'b1);
    wait_rv(10, n);
    check("mret1_rv_latency", n, 2);
    check("mret1_rpc", bus.redirect_pc, 32'h0000_0500);
    step();
    wait_flush(5, n);
    check("msi_take_latency", n, 1);
    wait_rv(10, n);
    check("msi_rpc", bus.redirect_pc, 32'h0000_020C);
    step();
    bus.msip = 1'b0;
    chk_csr("msi_mcause", CSR_MCAUSE, 32'h8000_0003);
    chk_csr("msi_mepc", CSR_MEPC, 32'h0000_0044);

    // MRET with a stalled redirect acceptance
    csr_wr(CSR_MEPC, 32'h0000_0300);
    csr_wr(CSR_MSTATUS, 32'h0000_0080);
    bus.redirect_ready = 1'b0;
    bus.mret_valid     = 1'b1;
    step();
    bus.mret_valid = 1'b0;
    wait_rv(10, n);
    check("mret2_rv_latency", n, 2);
    check("mret2_rpc", bus.redirect_pc, 32'h0000_0300);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (!bus.redirect_valid || bus.redirect_pc !== 32'h0000_0300 || !bus.busy) cnt++;
    end
    check("mret2_stall_stable", cnt, 0);
    bus.redirect_ready = 1'b1;
    step();
    check1("mret2_done_busy", bus.busy, 1'b0);
    check1("mret2_done_rv", bus.redirect_valid, 1'b0);
    chk_csr("mret2_mstatus", CSR_MSTATUS, 32'h0000_1888);

    // Asynchronous reset while draining
    bus.pipeline_empty = 1'b0;
    bus.exc_valid      = 1'b1;
    bus.exc_code       = LOAD_ACCESS_FAULT;
    bus.exc_pc         = 32'h0000_0600;
    step();
    bus.exc_valid = 1'b0;
    check1("rstmid_flush_before", bus.flush, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check1("rstmid_flush", bus.flush, 1'b0);
    check1("rstmid_busy", bus.busy, 1'b0);
    check1("rstmid_rv", bus.redirect_valid, 1'b0);
    chk_csr("rstmid_mepc", CSR_MEPC, 32'h0);
    chk_csr("rstmid_mstatus", CSR_MSTATUS, 32'h0000_1800);
    chk_csr("rstmid_mtvec", CSR_MTVEC, RST_MTVEC);
    step();
    rst_n              = 1'b1;
    bus.pipeline_empty = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.redirect_valid || bus.busy || bus.flush) cnt++;
    end
    check("rstmid_no_redirect", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
